scan_multiplexer: RTL
=====================

Name: scan_multiplexer

Overview:
Parametrised N-channel, WIDTH-bit registered multiplexer. It generalises the 2:1 4-bit combinational multiplexer to CHANNELS inputs and adds two selection modes: manual selection and an auto-scan mode that steps through the channels at a programmable dwell. It sits between parallel data sources (switch banks, counters) and a shared consumer such as a display driver on the Basys3. The output is registered, and a strobe marks each channel change.

Parameters:
WIDTH, 4, bit width of each channel
CHANNELS, 4, number of input channels; legal range 2..16
SCAN_DIV, 4, clock cycles spent on each channel in auto-scan mode; legal range 1..65535
SELW, derived as max(1, clog2(CHANNELS)), selector and channel-index width; not overridable

Ports:
Clk  input  1  system clock, rising-edge active
ResetN  input  1  asynchronous active-low reset
DataIn  input  CHANNELS*WIDTH  packed channels; channel k occupies bits [k*WIDTH +: WIDTH]
Selector  input  SELW  channel index used in manual mode
Mode  input  1  0 = manual, 1 = auto-scan
Hold  input  1  freezes the current state while high
DataOut  output  WIDTH  registered selected data
ChannelOut  output  SELW  registered index of the channel currently on DataOut
ChannelStep  output  1  one-cycle pulse when ChannelOut changes value
SelError  output  1  registered flag; high while a manual Selector value is ≥ CHANNELS

Behaviour:
- One clock (Clk). Reset is asynchronous and active-low (ResetN). All state is cleared immediately when ResetN falls, independent of Clk.
- Reset values: DataOut = 0, ChannelOut = 0, ChannelStep = 0, SelError = 0, internal dwell counter = 0.
- Latency: DataOut and ChannelOut are registered. They reflect the selection and DataIn sampled at the previous rising edge, giving 1 cycle of latency.
- DataOut tracks DataIn[ChannelOut] every cycle that Hold = 0, including when the same channel remains selected.
- Manual mode (Mode = 0, Hold = 0):
  - ChannelOut <= Selector.
  - If Selector ≥ CHANNELS: DataOut <= 0, SelError <= 1, and ChannelOut is loaded with the raw Selector value.
  - Otherwise SelError <= 0.
  - The dwell counter is held at 0.
- Auto-scan mode (Mode = 1, Hold = 0):
  - The dwell counter increments each cycle.
  - When the counter = SCAN_DIV-1, the counter returns to 0 and ChannelOut advances by 1, wrapping from CHANNELS-1 to 0.
  - Selector is ignored and SelError <= 0.
  - SCAN_DIV = 1 advances the channel every cycle.
- Mode change manual→auto: scanning starts from the current ChannelOut with the counter at 0. If ChannelOut ≥ CHANNELS at that moment, the next ChannelOut is 0.
- Mode change auto→manual: Selector takes effect at the same edge at which Mode = 0 is sampled, and the counter clears.
- Hold = 1 (either mode):
  - DataOut, ChannelOut, SelError and the counter all keep their values.
  - ChannelStep = 0.
  - Hold has priority over Mode changes. A Mode change sampled while Hold = 1 takes effect at the first edge with Hold = 0.
- ChannelStep: registered and high for exactly one cycle after any edge where ChannelOut is loaded with a value different from its previous value. A manual Selector that stays constant produces no further pulses.
- Reset mid-scan: the counter and channel return to 0. After release, scanning restarts at channel 0 with a full SCAN_DIV dwell.
- Widths: the counter is sized as clog2(SCAN_DIV) bits, minimum 1. No arithmetic overflow is permitted; wrap comparisons are explicit, not modulo-2^n.

Test Plan:
- Reset: WIDTH = 4, CHANNELS = 4. Assert ResetN = 0 mid-cycle with DataIn = 16'hDCBA and Mode = 1 → all outputs are 0 immediately, without waiting for a clock edge. Release ResetN → the first channel step occurs after exactly 4 cycles.
- Manual sweep: Mode = 0, DataIn = 16'h4321, Selector = 0..3, each held for 2 cycles → one cycle later DataOut = 1, 2, 3, 4 in turn. ChannelStep pulses once per change. SelError stays 0.
- Out-of-range: CHANNELS = 3, SELW = 2, Selector = 3 → DataOut = 0 and SelError = 1 after 1 cycle. Selector = 1 → SelError = 0 and DataOut = DataIn[7:4].
- Auto-scan wrap: CHANNELS = 4, SCAN_DIV = 3, Mode = 1, Hold = 0 → ChannelOut follows 0,0,0,1,1,1,2,2,2,3,3,3,0. ChannelStep pulses every 3rd cycle, including on the 3→0 wrap.
- Hold: in auto-scan, assert Hold = 1 for 5 cycles while on channel 2, with the counter at 1 → outputs are frozen and ChannelStep = 0. After release, channel 3 appears 2 cycles later. DataIn changes during Hold are not reflected on DataOut.
- Mode switch: in auto-scan on channel 1, set Mode = 0 with Selector = 3 → ChannelOut = 3 on the next edge. Set Mode = 1 again → scanning continues from 3 and the 3→0 wrap occurs after SCAN_DIV cycles.

Source files
------------

// File: rtl/scan_multiplexer.sv
// N-channel registered multiplexer with a manual select mode and an auto-scan mode.
// Auto-scan stays SCAN_DIV cycles on each channel; ChannelStep pulses on every channel change.
module scan_multiplexer #(
  parameter  int WIDTH    = 4,
  parameter  int CHANNELS = 4,
  parameter  int SCAN_DIV = 4,
  localparam int SELW     = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                      Clk,
  input  logic                      ResetN,
  input  logic [CHANNELS*WIDTH-1:0] DataIn,
  input  logic [SELW-1:0]           Selector,
  input  logic                      Mode,
  input  logic                      Hold,
  output logic [WIDTH-1:0]          DataOut,
  output logic [SELW-1:0]           ChannelOut,
  output logic                      ChannelStep,
  output logic                      SelError
);

  localparam int              CNTW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SELW:0]   CH_COUNT = (SELW+1)'(CHANNELS);
  localparam logic [SELW-1:0] CH_LAST  = SELW'(CHANNELS - 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(SCAN_DIV - 1);

  logic [WIDTH-1:0] data_q, data_d;
  logic [SELW-1:0]  ch_q, ch_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             step_q, step_d;
  logic             err_q, err_d;

  function automatic logic in_range(input logic [SELW-1:0] idx);
    in_range = ({1'b0, idx} < CH_COUNT);
  endfunction

  // Loop-based select keeps every part-select inside DataIn even for raw Selector values.
  function automatic logic [WIDTH-1:0] pick(input logic [CHANNELS*WIDTH-1:0] din,
                                            input logic [SELW-1:0] idx);
    pick = {WIDTH{1'b0}};
    for (int k = 0; k < CHANNELS; k++) begin
      if (idx == SELW'(k)) begin
        pick = din[k*WIDTH +: WIDTH];
      end else begin
        pick = pick;
      end
    end
  endfunction

  // Next-state selection: Hold freezes everything, otherwise manual or scan stepping.
  always_comb begin
    data_d = data_q;
    ch_d   = ch_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    step_d = 1'b0;
    if (!Hold) begin
      if (!Mode) begin
        ch_d  = Selector;
        cnt_d = {CNTW{1'b0}};
        err_d = !in_range(Selector);
      end else begin
        err_d = 1'b0;
        if (!in_range(ch_q)) begin
          ch_d  = {SELW{1'b0}};
          cnt_d = {CNTW{1'b0}};
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = {CNTW{1'b0}};
          ch_d  = (ch_q == CH_LAST) ? {SELW{1'b0}} : ch_q + SELW'(1'b1);
        end else begin
          cnt_d = cnt_q + CNTW'(1'b1);
        end
      end
      data_d = in_range(ch_d) ? pick(DataIn, ch_d) : {WIDTH{1'b0}};
      step_d = (ch_d != ch_q);
    end else begin
      step_d = 1'b0;
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      data_q <= {WIDTH{1'b0}};
      ch_q   <= {SELW{1'b0}};
      cnt_q  <= {CNTW{1'b0}};
      step_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      ch_q   <= ch_d;
      cnt_q  <= cnt_d;
      step_q <= step_d;
      err_q  <= err_d;
    end
  end

  assign DataOut     = data_q;
  assign ChannelOut  = ch_q;
  assign ChannelStep = step_q;
  assign SelError    = err_q;

endmodule
